// File: rtl/bnn_pkg.sv
// Shared types and defaults for the BNN XNOR-popcount sequencer.
package bnn_pkg;

    localparam int unsigned CHUNK_W_DEF = 32;
    localparam int unsigned MS_W_DEF    = 10;
    localparam int unsigned IDX_W_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        EXPATH_ALU = 2'd0,
        EXPATH_MUL = 2'd1,
        EXPATH_MEM = 2'd2,
        EXPATH_BNN = 2'd3
    } expath_t;

endpackage

// File: rtl/bnn_chunk_counter.sv
// Chunk bookkeeping for the BNN sequencer: chunk count, index counter and last-chunk mask.
module bnn_chunk_counter
    import bnn_pkg::*;
#(
    parameter int unsigned CHUNK_W = CHUNK_W_DEF,
    parameter int unsigned MS_W    = MS_W_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MS_W-1:0]    i_ms,
    input  logic               i_load,
    input  logic               i_run,
    output logic [IDX_W:0]     o_nchunks,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_last,
    output logic [CHUNK_W-1:0] o_mask
);

    localparam int unsigned REM_W = $clog2(CHUNK_W);

    logic [REM_W-1:0] w_rem;
    logic [REM_W-1:0] r_rem;
    logic [IDX_W:0]   r_nchunks;
    logic [IDX_W-1:0] r_idx;

    assign o_nchunks = (IDX_W+1)'(({1'b0, i_ms} + (MS_W+1)'(CHUNK_W - 1)) / (MS_W+1)'(CHUNK_W));
    assign w_rem     = REM_W'(i_ms % MS_W'(CHUNK_W));

    // Count and remainder are captured at start so a config write landing on that edge cannot disturb the op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nchunks <= '0;
            r_rem     <= '0;
            r_idx     <= '0;
        end else begin
            if (i_load) begin
                r_nchunks <= o_nchunks;
                r_rem     <= w_rem;
            end
            if (i_run && !o_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end else begin
                r_idx <= '0;
            end
        end
    end

    assign o_idx  = r_idx;
    assign o_last = i_run && (({1'b0, r_idx} + (IDX_W+1)'(1)) == r_nchunks);

    always_comb begin
        o_mask = '1;
        if (o_last && (r_rem != '0)) begin
            o_mask = (CHUNK_W'(1) << r_rem) - CHUNK_W'(1);
        end
    end

endmodule

// File: rtl/bnn_seq_ctrl.sv
// Multi-cycle sequencer for the BNN XNOR-popcount unit: config registers, FSM, accumulator
// and pipeline stall request.
module bnn_seq_ctrl
    import bnn_pkg::*;
#(
    parameter int unsigned CHUNK_W = CHUNK_W_DEF,
    parameter int unsigned MS_W    = MS_W_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_E,
    input  logic                       en_thresh_E,
    input  logic                       ms_WE_E,
    input  logic                       at_WE_E,
    input  logic [MS_W:0]              cfg_wd_E,
    input  logic [$clog2(CHUNK_W):0]   pop_in,
    output logic [IDX_W-1:0]           chunk_idx,
    output logic [CHUNK_W-1:0]         chunk_mask,
    output logic                       stall_req,
    output logic                       result_valid,
    output logic [31:0]                result,
    output logic [MS_W-1:0]            matrix_size,
    output logic [MS_W:0]              threshold
);

    seq_state_t r_state, w_next;

    logic [MS_W-1:0] r_ms;
    logic [MS_W:0]   r_thr;
    logic [MS_W:0]   r_thr_op;
    logic [MS_W:0]   r_acc;
    logic            r_en_thr;
    logic            w_load;
    logic            w_run;
    logic            w_last;
    logic [IDX_W:0]  w_nchunks;

    assign w_run  = (r_state == RUN);
    assign w_load = (r_state == IDLE) && start_E;

    bnn_chunk_counter #(
        .CHUNK_W (CHUNK_W),
        .MS_W    (MS_W),
        .IDX_W   (IDX_W)
    ) u_chunk_counter (
        .clk       (clk),
        .reset     (reset),
        .i_ms      (r_ms),
        .i_load    (w_load),
        .i_run     (w_run),
        .o_nchunks (w_nchunks),
        .o_idx     (chunk_idx),
        .o_last    (w_last),
        .o_mask    (chunk_mask)
    );

    always_comb begin
        w_next       = r_state;
        stall_req    = 1'b0;
        result_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                stall_req = start_E;
                if (start_E) begin
                    w_next = (w_nchunks == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                stall_req = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Threshold is snapshotted with the op so a same-edge at write only affects later ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ms     <= MS_W'(CHUNK_W);
            r_thr    <= '0;
            r_thr_op <= '0;
            r_en_thr <= 1'b0;
            r_acc    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                if (ms_WE_E) r_ms  <= cfg_wd_E[MS_W-1:0];
                if (at_WE_E) r_thr <= cfg_wd_E;
            end
            if (w_load) begin
                r_acc    <= '0;
                r_en_thr <= en_thresh_E;
                r_thr_op <= r_thr;
            end else if (w_run) begin
                r_acc <= r_acc + (MS_W+1)'(pop_in);
            end
        end
    end

    always_comb begin
        result = '0;
        if (r_state == DONE) begin
            result = r_en_thr ? 32'(r_acc >= r_thr_op) : 32'(r_acc);
        end
    end

    assign matrix_size = r_ms;
    assign threshold   = r_thr;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Self-checking bench for bnn_seq_ctrl: directed scenarios plus randomized ops against a
// ceil-division / summation reference model.
`timescale 1ns/1ps
module tb_bnn_seq_ctrl;

    localparam int CHUNK_W = 32;
    localparam int MS_W    = 10;
    localparam int IDX_W   = 5;
    localparam int POP_W   = 6;

    logic               clk = 1'b0;
    logic               reset;
    logic               start_E;
    logic               en_thresh_E;
    logic               ms_WE_E;
    logic               at_WE_E;
    logic [MS_W:0]      cfg_wd_E;
    logic [POP_W-1:0]   pop_in;
    logic [IDX_W-1:0]   chunk_idx;
    logic [CHUNK_W-1:0] chunk_mask;
    logic               stall_req;
    logic               result_valid;
    logic [31:0]        result;
    logic [MS_W-1:0]    matrix_size;
    logic [MS_W:0]      threshold;

    int checks   = 0;
    int failures = 0;

    int               pop_tab  [64];
    logic [IDX_W-1:0] obs_idx  [64];
    logic [31:0]      obs_mask [64];
    bit               wr_at_start;
    bit               wr_during_run;
    logic [MS_W:0]    wr_data;

    bnn_seq_ctrl #(
        .CHUNK_W (CHUNK_W),
        .MS_W    (MS_W),
        .IDX_W   (IDX_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_E      (start_E),
        .en_thresh_E  (en_thresh_E),
        .ms_WE_E      (ms_WE_E),
        .at_WE_E      (at_WE_E),
        .cfg_wd_E     (cfg_wd_E),
        .pop_in       (pop_in),
        .chunk_idx    (chunk_idx),
        .chunk_mask   (chunk_mask),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .result       (result),
        .matrix_size  (matrix_size),
        .threshold    (threshold)
    );

    always #5 clk = ~clk;

    // Stimulus only: one op held in Execute while stalled, observations recorded per cycle.
    task automatic do_op(input logic en, output int n_stall, output int valid_cyc,
                         output int n_valid, output logic [31:0] res, output bit timed_out);
        n_stall = 0; valid_cyc = -1; n_valid = 0; res = '0; timed_out = 1'b1;
        start_E = 1'b1; en_thresh_E = en;
        for (int c = 0; c < 48; c++) begin
            pop_in   = (c >= 1) ? POP_W'(pop_tab[c-1]) : '0;
            ms_WE_E  = (c == 0) ? wr_at_start : wr_during_run;
            at_WE_E  = ms_WE_E;
            cfg_wd_E = wr_data;
            @(negedge clk);
            obs_idx[c]  = chunk_idx;
            obs_mask[c] = chunk_mask;
            if (stall_req) n_stall++;
            if (result_valid) begin
                n_valid++;
                if (valid_cyc < 0) begin valid_cyc = c; res = result; end
            end
            @(posedge clk); #1;
            if (valid_cyc >= 0) begin timed_out = 1'b0; break; end
        end
        start_E = 1'b0; en_thresh_E = 1'b0; pop_in = '0; ms_WE_E = 1'b0; at_WE_E = 1'b0;
    endtask

    task automatic cfg_write(input logic ms_we, input logic at_we, input logic [MS_W:0] d);
        ms_WE_E = ms_we; at_WE_E = at_we; cfg_wd_E = d;
        @(posedge clk); #1;
        ms_WE_E = 1'b0; at_WE_E = 1'b0; cfg_wd_E = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_E = 1'b0; en_thresh_E = 1'b0; ms_WE_E = 1'b0; at_WE_E = 1'b0;
        cfg_wd_E = '0; pop_in = '0; wr_at_start = 1'b0; wr_during_run = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (chunk_idx !== '0) begin failures++; $display("FAIL rst_idx got=%0d exp=0", chunk_idx); end
        checks++; if (chunk_mask !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_mask got=%08h exp=ffffffff", chunk_mask); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_req); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", result_valid); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL rst_result got=%0d exp=0", result); end
        checks++; if (matrix_size !== 10'd32) begin failures++; $display("FAIL rst_ms got=%0d exp=32", matrix_size); end
        checks++; if (threshold !== 11'd0) begin failures++; $display("FAIL rst_thr got=%0d exp=0", threshold); end
        @(posedge clk); #1;
    endtask

    task automatic test_config();
        cfg_write(1'b1, 1'b0, 11'd64);
        cfg_write(1'b0, 1'b1, 11'd40);
        @(negedge clk);
        checks++; if (matrix_size !== 10'd64) begin failures++; $display("FAIL cfg_ms got=%0d exp=64", matrix_size); end
        checks++; if (threshold !== 11'd40) begin failures++; $display("FAIL cfg_thr got=%0d exp=40", threshold); end
        @(posedge clk); #1;
    endtask

    task automatic test_two_chunk();
        int ns, vc, nv; logic [31:0] r; bit to;
        pop_tab[0] = 20; pop_tab[1] = 25;
        do_op(1'b0, ns, vc, nv, r, to);
        checks++; if (to) begin failures++; $display("FAIL two_timeout got=timeout exp=valid"); end
        checks++; if (ns !== 3) begin failures++; $display("FAIL two_stall got=%0d exp=3", ns); end
        checks++; if (vc !== 3) begin failures++; $display("FAIL two_valid_cyc got=%0d exp=3", vc); end
        checks++; if (r !== 32'd45) begin failures++; $display("FAIL two_result got=%0d exp=45", r); end
        checks++; if (obs_idx[1] !== 5'd0) begin failures++; $display("FAIL two_idx0 got=%0d exp=0", obs_idx[1]); end
        checks++; if (obs_idx[2] !== 5'd1) begin failures++; $display("FAIL two_idx1 got=%0d exp=1", obs_idx[2]); end
        checks++; if (obs_mask[2] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL two_mask got=%08h exp=ffffffff", obs_mask[2]); end
        // start_E was still high in DONE; the sequencer must now be idle, not restarted.
        @(negedge clk);
        checks++; if (stall_req !== 1'b0 || result_valid !== 1'b0) begin
            failures++; $display("FAIL two_no_restart got=stall%b/valid%b exp=0/0", stall_req, result_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_partial_thresh();
        int ns, vc, nv; logic [31:0] r; bit to;
        cfg_write(1'b1, 1'b0, 11'd70);
        pop_tab[0] = 20; pop_tab[1] = 13; pop_tab[2] = 6;
        do_op(1'b1, ns, vc, nv, r, to);
        checks++; if (ns !== 4 || to) begin failures++; $display("FAIL p70_stall got=%0d exp=4", ns); end
        checks++; if (obs_mask[3] !== 32'h0000_003F) begin failures++; $display("FAIL p70_mask_last got=%08h exp=0000003f", obs_mask[3]); end
        checks++; if (obs_mask[2] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL p70_mask_mid got=%08h exp=ffffffff", obs_mask[2]); end
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL p70_thr39 got=%0d exp=0", r); end
        pop_tab[1] = 14;
        do_op(1'b1, ns, vc, nv, r, to);
        checks++; if (r !== 32'd1 || to) begin failures++; $display("FAIL p70_thr40 got=%0d exp=1", r); end
        do_op(1'b0, ns, vc, nv, r, to);
        checks++; if (r !== 32'd40 || to) begin failures++; $display("FAIL p70_raw got=%0d exp=40", r); end
    endtask

    task automatic test_zero_size();
        int ns, vc, nv; logic [31:0] r; bit to;
        cfg_write(1'b1, 1'b0, 11'd0);
        do_op(1'b0, ns, vc, nv, r, to);
        checks++; if (ns !== 1 || to) begin failures++; $display("FAIL zero_stall got=%0d exp=1", ns); end
        checks++; if (vc !== 1) begin failures++; $display("FAIL zero_valid_cyc got=%0d exp=1", vc); end
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL zero_result got=%0d exp=0", r); end
        do_op(1'b1, ns, vc, nv, r, to);
        checks++; if (r !== 32'd0 || to) begin failures++; $display("FAIL zero_thr40 got=%0d exp=0", r); end
        cfg_write(1'b0, 1'b1, 11'd0);
        do_op(1'b1, ns, vc, nv, r, to);
        checks++; if (r !== 32'd1 || to) begin failures++; $display("FAIL zero_thr0 got=%0d exp=1", r); end
    endtask

    task automatic test_cfg_during_run();
        int ns, vc, nv; logic [31:0] r; bit to;
        cfg_write(1'b1, 1'b1, 11'd64);
        pop_tab[0] = 3; pop_tab[1] = 4;
        wr_during_run = 1'b1; wr_data = 11'd100;
        do_op(1'b0, ns, vc, nv, r, to);
        wr_during_run = 1'b0;
        checks++; if (ns !== 3 || to) begin failures++; $display("FAIL run_wr_stall got=%0d exp=3", ns); end
        checks++; if (matrix_size !== 10'd64) begin failures++; $display("FAIL run_wr_ms got=%0d exp=64", matrix_size); end
        checks++; if (threshold !== 11'd64) begin failures++; $display("FAIL run_wr_thr got=%0d exp=64", threshold); end
    endtask

    task automatic test_simul_write_start();
        int ns, vc, nv; logic [31:0] r; bit to;
        pop_tab[0] = 10; pop_tab[1] = 11;
        wr_at_start = 1'b1; wr_data = 11'd32;
        do_op(1'b0, ns, vc, nv, r, to);
        wr_at_start = 1'b0;
        checks++; if (ns !== 3 || to) begin failures++; $display("FAIL simul_stall got=%0d exp=3", ns); end
        checks++; if (r !== 32'd21) begin failures++; $display("FAIL simul_result got=%0d exp=21", r); end
        checks++; if (matrix_size !== 10'd32) begin failures++; $display("FAIL simul_ms got=%0d exp=32", matrix_size); end
        do_op(1'b0, ns, vc, nv, r, to);
        checks++; if (ns !== 2 || to) begin failures++; $display("FAIL simul_next_stall got=%0d exp=2", ns); end
    endtask

    task automatic test_reset_mid_run();
        int ns, vc, nv, pulses; logic [31:0] r; bit to;
        cfg_write(1'b1, 1'b0, 11'd64);
        start_E = 1'b1; pop_in = '0;
        @(posedge clk); #1 pop_in = 6'd5;
        @(posedge clk); #1 pop_in = 6'd5; reset = 1'b1;
        @(negedge clk);
        checks++; if (chunk_idx !== 5'd1 || stall_req !== 1'b1) begin
            failures++; $display("FAIL mid_chunk1 got=idx%0d/stall%b exp=1/1", chunk_idx, stall_req); end
        @(posedge clk); #1 reset = 1'b0; start_E = 1'b0; pop_in = '0;
        @(negedge clk);
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL mid_stall got=%b exp=0", stall_req); end
        checks++; if (matrix_size !== 10'd32) begin failures++; $display("FAIL mid_ms got=%0d exp=32", matrix_size); end
        checks++; if (chunk_idx !== 5'd0) begin failures++; $display("FAIL mid_idx got=%0d exp=0", chunk_idx); end
        pulses = result_valid ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL mid_valid_pulse got=%0d exp=0", pulses); end
        @(posedge clk); #1;
        pop_tab[0] = 17;
        do_op(1'b0, ns, vc, nv, r, to);
        checks++; if (ns !== 2 || r !== 32'd17 || to) begin
            failures++; $display("FAIL mid_after got=stall%0d/res%0d exp=2/17", ns, r); end
    endtask

    task automatic test_random();
        int ns, vc, nv, ms, thr, n, rem, bits, sum, exp_res;
        logic [31:0] r, exp_mask; bit to, en;
        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 7))
                0:       ms = 0;
                1:       ms = 32 * $urandom_range(1, 31);
                2:       ms = $urandom_range(993, 1023);
                default: ms = $urandom_range(1, 1023);
            endcase
            n   = (ms + CHUNK_W - 1) / CHUNK_W;
            rem = ms % CHUNK_W;
            sum = 0;
            for (int k = 0; k < n; k++) begin
                bits = (k == n - 1 && rem != 0) ? rem : CHUNK_W;
                pop_tab[k] = $urandom_range(0, bits);
                sum += pop_tab[k];
            end
            thr = $urandom_range(0, 1) ? sum + $urandom_range(0, 2) - 1 : $urandom_range(0, 2047);
            if (thr < 0) thr = 0;
            if (thr > 2047) thr = 2047;
            en = 1'($urandom_range(0, 1));
            exp_res = en ? ((sum >= thr) ? 1 : 0) : sum;
            cfg_write(1'b1, 1'b0, 11'(ms));
            cfg_write(1'b0, 1'b1, 11'(thr));
            do_op(en, ns, vc, nv, r, to);
            checks++; if (to) begin failures++; $display("FAIL rnd_timeout it=%0d ms=%0d", it, ms); end
            checks++; if (ns !== n + 1) begin failures++; $display("FAIL rnd_stall it=%0d got=%0d exp=%0d", it, ns, n + 1); end
            checks++; if (vc !== n + 1 || nv !== 1) begin
                failures++; $display("FAIL rnd_valid it=%0d got=cyc%0d/n%0d exp=%0d/1", it, vc, nv, n + 1); end
            checks++; if (r !== 32'(exp_res)) begin
                failures++; $display("FAIL rnd_result it=%0d ms=%0d thr=%0d en=%b got=%0d exp=%0d", it, ms, thr, en, r, exp_res); end
            if (!to) begin
                for (int k = 0; k < n; k++) begin
                    exp_mask = (k == n - 1 && rem != 0) ? ((32'h1 << rem) - 32'h1) : 32'hFFFF_FFFF;
                    checks++; if (obs_mask[k+1] !== exp_mask || obs_idx[k+1] !== 5'(k)) begin
                        failures++;
                        $display("FAIL rnd_chunk it=%0d k=%0d got=idx%0d/%08h exp=idx%0d/%08h",
                                 it, k, obs_idx[k+1], obs_mask[k+1], k, exp_mask);
                    end
                end
            end
            @(negedge clk);
            checks++; if (stall_req !== 1'b0 || result_valid !== 1'b0) begin
                failures++; $display("FAIL rnd_idle it=%0d got=stall%b/valid%b exp=0/0", it, stall_req, result_valid); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_two_chunk();
        test_partial_thresh();
        test_zero_size();
        test_cfg_during_run();
        test_simul_write_start();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
